// File: rtl/escaneo_teclado_if.sv
// Keypad pin bundle plus the {codigo, key_detect} result consumed by key translation.
interface escaneo_teclado_if;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] codigo;
    logic       key_detect;

    modport master (output filas, input columnas, input codigo, input key_detect);
    modport slave  (input filas, output columnas, output codigo, output key_detect);
endinterface

// File: rtl/escaneo_teclado.sv
// 4x4 keypad scanner: column strobing, row synchronisation, press/release debounce,
// one key_detect pulse per physical press.
//
// state        | meaning
// SCAN         | drive one column per slot, look for any low row at slot end
// DEBOUNCE     | row pattern must stay identical for DEBOUNCE_CNT cycles
// PRESSED      | single cycle: codigo updated, key_detect high
// WAIT_RELEASE | column frozen until rows idle for DEBOUNCE_CNT cycles
module escaneo_teclado #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    escaneo_teclado_if.slave   bus
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SCAN_LOAD = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LOAD  = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, WAIT_RELEASE} estado_t;

    estado_t       estado, estado_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    col, col_d;
    logic [3:0]    patron, patron_d;
    logic [3:0]    codigo_q, codigo_d;
    logic          key_detect_q, key_detect_d;
    logic [3:0]    columnas_q, columnas_d;
    logic [3:0]    filas_m, filas_s;

    function automatic logic [1:0] fila_min(input logic [3:0] p);
        if (!p[0])      return 2'd0;
        else if (!p[1]) return 2'd1;
        else if (!p[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // Rows idle high, so the synchroniser resets to "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filas_m <= 4'hF;
            filas_s <= 4'hF;
        end else begin
            filas_m <= bus.filas;
            filas_s <= filas_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= SCAN;
            cnt          <= SCAN_LOAD;
            col          <= 2'd0;
            patron       <= 4'hF;
            codigo_q     <= 4'h0;
            key_detect_q <= 1'b0;
            columnas_q   <= 4'b1110;
        end else begin
            estado       <= estado_d;
            cnt          <= cnt_d;
            col          <= col_d;
            patron       <= patron_d;
            codigo_q     <= codigo_d;
            key_detect_q <= key_detect_d;
            columnas_q   <= columnas_d;
        end
    end

    // Timers are down-counters: reload on entry, act when they reach zero.
    always_comb begin
        estado_d     = estado;
        cnt_d        = cnt;
        col_d        = col;
        patron_d     = patron;
        codigo_d     = codigo_q;
        key_detect_d = 1'b0;
        case (estado)
            SCAN: begin
                if (cnt == '0) begin
                    if (filas_s == 4'hF) begin
                        col_d = col + 2'd1;
                        cnt_d = SCAN_LOAD;
                    end else begin
                        patron_d = filas_s;
                        cnt_d    = DEB_LOAD;
                        estado_d = DEBOUNCE;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DEBOUNCE: begin
                if (filas_s != patron) begin
                    estado_d = SCAN;
                    col_d    = col + 2'd1;
                    cnt_d    = SCAN_LOAD;
                end else if (cnt == '0) begin
                    estado_d     = PRESSED;
                    key_detect_d = 1'b1;
                    codigo_d     = {fila_min(patron), col};
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            PRESSED: begin
                estado_d = WAIT_RELEASE;
                cnt_d    = DEB_LOAD;
            end
            WAIT_RELEASE: begin
                if (filas_s != 4'hF) begin
                    cnt_d = DEB_LOAD;
                end else if (cnt == '0) begin
                    estado_d = SCAN;
                    col_d    = col + 2'd1;
                    cnt_d    = SCAN_LOAD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: begin
                estado_d = SCAN;
                cnt_d    = SCAN_LOAD;
            end
        endcase
        columnas_d = ~(4'b0001 << col_d);
    end

    assign bus.columnas   = columnas_q;
    assign bus.codigo     = codigo_q;
    assign bus.key_detect = key_detect_q;

endmodule

// File: tb/tb_escaneo_teclado.sv
// Bench for escaneo_teclado: keypad matrix model, vector table, scoreboard of expected codes.
module tb_escaneo_teclado;
    localparam int SD = 4;
    localparam int DC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] teclas;   // bit r*4+c = key at row r, column c pressed

    always #5 clk = ~clk;

    escaneo_teclado_if bus();

    always_comb begin
        bus.filas = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (teclas[r*4+c] && !bus.columnas[c]) bus.filas[r] = 1'b0;
    end

    escaneo_teclado #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] keys;
        logic [15:0] extra;
        logic [3:0]  code;
        int          col;
        int          hold;
    } vec_t;

    vec_t tabla[6];
    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;
    logic kd_prev = 1'b0;
    logic [3:0] q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] colmask(input int c);
        logic [3:0] m;
        m = 4'b0001 << c;
        return ~m;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int base, input string name);
        for (int i = 0; i < 60 && n_pulse == base; i++) tick();
        chk(name, n_pulse - base, 1);
    endtask

    // Pulse monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst_n) begin
            chk("columnas_onehot",
                int'(bus.columnas inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}), 1);
            if (bus.key_detect) begin
                n_pulse++;
                chk("kd_double", int'(kd_prev), 0);
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: codigo %0h, none queued at %0t",
                             bus.codigo, $time);
                end else begin
                    e = q.pop_front();
                    chk("pulse_codigo", bus.codigo, e);
                end
            end
            kd_prev = bus.key_detect;
        end else begin
            kd_prev = 1'b0;
        end
    end

    initial begin
        int base;
        teclas = 16'h0;
        rst_n  = 1'b0;
        tabla[0] = '{keys: 16'h0020, extra: 16'h0, code: 4'b0101, col: 1, hold: 200};
        tabla[1] = '{keys: 16'h0001, extra: 16'h0, code: 4'b0000, col: 0, hold: 30};
        tabla[2] = '{keys: 16'h0800, extra: 16'h0, code: 4'b1011, col: 3, hold: 30};
        tabla[3] = '{keys: 16'h1000, extra: 16'h0, code: 4'b1100, col: 0, hold: 30};
        tabla[4] = '{keys: 16'h0404, extra: 16'h0010, code: 4'b0010, col: 2, hold: 30};
        tabla[5] = '{keys: 16'h8080, extra: 16'h0, code: 4'b0111, col: 3, hold: 30};

        repeat (3) tick();
        chk("rst_columnas", bus.columnas, 4'b1110);
        chk("rst_codigo", bus.codigo, 4'h0);
        chk("rst_kd", bus.key_detect, 0);

        // Idle scan: each column held for SD cycles
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            chk("idle_col", bus.columnas, colmask((k / SD) % 4));
        end
        chk("idle_pulses", n_pulse, 0);
        chk("idle_codigo", bus.codigo, 4'h0);

        for (int v = 0; v < 6; v++) begin
            base = n_pulse;
            q.push_back(tabla[v].code);
            teclas = tabla[v].keys;
            wait_pulse(base, "press_timeout");
            chk("codigo", bus.codigo, tabla[v].code);
            teclas = tabla[v].keys | tabla[v].extra;
            repeat (tabla[v].hold) tick();
            chk("held_col", bus.columnas, colmask(tabla[v].col));
            chk("pulses_per_press", n_pulse - base, 1);
            teclas = 16'h0;
            repeat (DC + 1) tick();
            chk("release_hold", bus.columnas, colmask(tabla[v].col));
            tick();
            chk("release_adv", bus.columnas, colmask((tabla[v].col + 1) % 4));
            repeat (10) tick();
        end

        // Bounced press on row3/col3
        base = n_pulse;
        q.push_back(4'b1111);
        teclas = 16'h8000; repeat (3) tick();
        teclas = 16'h0;    repeat (2) tick();
        teclas = 16'h8000; repeat (3) tick();
        chk("bounce_nopulse", n_pulse - base, 0);
        wait_pulse(base, "bounce_timeout");
        chk("bounce_codigo", bus.codigo, 4'b1111);
        repeat (20) tick();
        teclas = 16'h0;
        repeat (20) tick();
        chk("bounce_pulses", n_pulse - base, 1);

        // Short release must not re-arm; full release must
        base = n_pulse;
        q.push_back(4'b0101);
        teclas = 16'h0020;
        wait_pulse(base, "rep_timeout");
        repeat (10) tick();
        teclas = 16'h0;
        repeat (5) tick();
        teclas = 16'h0020;
        repeat (60) tick();
        chk("short_release_pulses", n_pulse - base, 1);
        chk("short_release_col", bus.columnas, 4'b1101);
        teclas = 16'h0;
        repeat (20) tick();
        base = n_pulse;
        q.push_back(4'b0101);
        teclas = 16'h0020;
        wait_pulse(base, "repress_timeout");
        chk("repress_codigo", bus.codigo, 4'b0101);
        teclas = 16'h0;
        repeat (20) tick();

        // Reset in the middle of debounce, key held throughout
        base = n_pulse;
        rst_n = 1'b0;
        repeat (2) tick();
        teclas = 16'h0200;
        @(negedge clk) rst_n = 1'b1;
        repeat (11) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_columnas", bus.columnas, 4'b1110);
        chk("midrst_codigo", bus.codigo, 4'h0);
        chk("midrst_kd", bus.key_detect, 0);
        repeat (2) tick();
        q.push_back(4'b1001);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("latency_kd", bus.key_detect, int'(k == 16));
        end
        repeat (20) tick();
        teclas = 16'h0;
        repeat (20) tick();
        chk("midrst_pulses", n_pulse - base, 1);
        chk("midrst_codigo_after", bus.codigo, 4'b1001);

        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
